// File: rtl/uart_loader.sv
// uart_loader: boot-time UART (8N1) image loader for a 4096x32 program/data memory
// Ports: clk, rst_n (async, active-low), rx (async serial in, idle high);
//   mem_addr/mem_data/mem_we: memory write port; core_hold: core stalled during a frame;
//   core_start: one-cycle restart pulse on success; busy: frame in progress;
//   error: sticky fault flag, cleared by the next 0xA5 sync byte.
// Optional feature: define UART_LOADER_CSUM_EN to expect and check a trailing XOR checksum byte.
`timescale 1ns/1ps
module uart_loader #(
  parameter int          CLK_HZ    = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [11:0] BASE_ADDR = 12'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        core_hold,
  output logic        core_start,
  output logic        busy,
  output logic        error
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_t;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR} st_t;
  rx_t rs;
  st_t st;
  logic rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh, len_lo;
  logic byte_vld, frm_err, fin;
  logic [1:0] idx;
  logic [11:0] words;
`ifdef UART_LOADER_CSUM_EN
  logic [7:0] csum;
`endif
  // RX front end; after a bad stop bit, wait for a high line so the tail of the bad byte is not taken as a start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rs <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      byte_vld <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      byte_vld <= 1'b0;
      frm_err <= 1'b0;
      cnt <= cnt + CW'(1);
      case (rs)
        R_START: if (cnt == CW'(DIV / 2 - 1)) begin
          cnt <= '0;
          bit_idx <= '0;
          rs <= rx_s ? R_IDLE : R_DATA;
        end
        R_DATA: if (cnt == CW'(DIV - 1)) begin
          cnt <= '0;
          sh <= {rx_s, sh[7:1]};
          bit_idx <= bit_idx + 3'd1;
          rs <= bit_idx == 3'd7 ? R_STOP : R_DATA;
        end
        R_STOP: if (cnt == CW'(DIV - 1)) begin
          cnt <= '0;
          byte_vld <= rx_s;
          frm_err <= !rx_s;
          rs <= rx_s ? R_IDLE : R_WAIT;
        end
        R_WAIT: begin
          cnt <= '0;
          rs <= rx_s ? R_IDLE : R_WAIT;
        end
        default: begin
          cnt <= '0;
          rs <= rx_s ? R_IDLE : R_START;
        end
      endcase
    end
  // Frame FSM; the address advances in the cycle after each write so addr/data hold through the strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      mem_addr <= BASE_ADDR;
      mem_data <= '0;
      mem_we <= 1'b0;
      core_hold <= 1'b0;
      core_start <= 1'b0;
      busy <= 1'b0;
      error <= 1'b0;
      len_lo <= '0;
      idx <= '0;
      words <= '0;
      fin <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
      csum <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      core_start <= 1'b0;
      fin <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + 12'd1;
      if (fin) begin
        core_hold <= 1'b0;
        core_start <= 1'b1;
      end
      if (frm_err) begin
        st <= ERR;
        error <= 1'b1;
        busy <= 1'b0;
      end else if (byte_vld)
        case (st)
          LEN_LO: begin
            len_lo <= sh;
            st <= LEN_HI;
          end
          LEN_HI: begin
            words <= {sh[3:0], len_lo};
            idx <= 2'd0;
            if (sh[7:4] != 4'd0) begin
              st <= ERR;
              error <= 1'b1;
              busy <= 1'b0;
            end else if ({sh[3:0], len_lo} != 12'd0)
              st <= DATA;
`ifdef UART_LOADER_CSUM_EN
            else
              st <= CSUM;
`else
            else begin
              st <= IDLE;
              core_hold <= 1'b0;
              core_start <= 1'b1;
              busy <= 1'b0;
            end
`endif
          end
          DATA: begin
            mem_data[{idx, 3'b000} +: 8] <= sh;
            idx <= idx + 2'd1;
`ifdef UART_LOADER_CSUM_EN
            csum <= csum ^ sh;
`endif
            if (idx == 2'd3) begin
              mem_we <= 1'b1;
              words <= words - 12'd1;
              if (words == 12'd1) begin
`ifdef UART_LOADER_CSUM_EN
                st <= CSUM;
`else
                st <= IDLE;
                fin <= 1'b1;
                busy <= 1'b0;
`endif
              end
            end
          end
`ifdef UART_LOADER_CSUM_EN
          CSUM: begin
            st <= sh == csum ? IDLE : ERR;
            core_hold <= sh != csum;
            core_start <= sh == csum;
            error <= sh != csum;
            busy <= 1'b0;
          end
`endif
          default: if (sh == 8'hA5) begin
            st <= LEN_LO;
            error <= 1'b0;
            core_hold <= 1'b1;
            busy <= 1'b1;
            mem_addr <= BASE_ADDR;
`ifdef UART_LOADER_CSUM_EN
            csum <= '0;
`endif
          end
        endcase
    end
endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader for the core's 4096×32 program/data memory. It receives a framed image over a UART RX line (8N1), assembles little-endian 32-bit words and writes them to consecutive memory addresses. It holds the core stalled while loading and pulses a restart when the image is complete. It sits upstream of the core and shares the memory's write port with it; the top level muxes on `core_hold`.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency.
- `BAUD`, default 115200: UART bit rate. Bit period `DIV = CLK_HZ/BAUD`, integer-truncated; must be ≥ 16.
- `BASE_ADDR`, default 12'd0: first write address.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx` in 1: UART serial input, idle high, asynchronous to `clk`.
- `mem_addr` out 12: write address.
- `mem_data` out 32: write data.
- `mem_we` out 1: one-cycle write strobe.
- `core_hold` out 1: high while a frame is in progress; core must not fetch or write.
- `core_start` out 1: one-cycle pulse on successful completion.
- `busy` out 1: frame receiver not idle.
- `error` out 1: sticky; cleared by the next sync byte or reset.

## Operation
- **RX front end**
  - `rx` passes through a 2-FF synchronizer (reset value 1).
  - A falling edge in RX idle starts a bit timer. At DIV/2 the start bit is re-checked; if it is high, it is a false start and RX returns to idle.
  - Data bits are sampled every DIV cycles, LSB first. The stop bit is sampled DIV after bit 7.
  - Stop bit = 1: one-cycle `byte_vld` with the byte.
  - Stop bit = 0: framing error. The frame FSM goes to ERR. RX returns to idle only after the synchronized `rx` is seen high.
- **Frame format:** `0xA5`, `LEN_LO`, `LEN_HI`, then 4×N data bytes (word LSB first), then `CSUM` (XOR of all data bytes; present only with the checksum feature). N = {LEN_HI[3:0], LEN_LO}.
- **Frame FSM states:** IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERR.
  - **IDLE:** bytes ≠ 0xA5 are ignored. 0xA5 clears `error`, asserts `core_hold`, loads `mem_addr` = BASE_ADDR and goes to LEN_LO.
  - **LEN_LO → LEN_HI:** latch the byte.
  - **LEN_HI:** if LEN_HI[7:4] ≠ 0, go to ERR. If N = 0, go to CSUM (or finish if the feature is off). Otherwise go to DATA.
  - **DATA:** 2-bit byte index; bytes shift into `mem_data[8k+7:8k]`. On the 4th byte, `mem_we` pulses; the address then increments (mod 4096, wrapping 4095→0). The word counter decrements. On the last word, go to CSUM / finish.
  - **CSUM:** byte equal to the running XOR → finish. Byte not equal → ERR.
  - **Finish:** `core_hold` drops, `core_start` pulses, go to IDLE.
  - **ERR:** `error` is set and `core_hold` stays high, so the core stays stalled with a partial image. The FSM behaves as IDLE (waits for 0xA5). Words already written are not rolled back.
- A 0xA5 byte inside DATA/LEN is data, not a resync.
- **Reset mid-frame:** all state is discarded and outputs return to reset values; the core is released with whatever memory holds.
- **Reset values:** `mem_addr` = BASE_ADDR, `mem_data` = 0, `mem_we` = 0, `core_hold` = 0, `core_start` = 0, `busy` = 0, `error` = 0.

## Timing
- **Synchronizer latency:** 2 cycles from the `rx` edge.
- **Byte latency:** `byte_vld` occurs 1 cycle after the stop-bit sample.
- **Write timing:** `mem_we` is asserted in the cycle after the 4th byte's `byte_vld`. `mem_addr` and `mem_data` are stable during that cycle and change no earlier than the following cycle.
- `core_hold` rises the cycle after the 0xA5 `byte_vld`.
- **Completion:** `core_hold` falls in the same cycle `core_start` is high. That is 1 cycle after the CSUM `byte_vld`, or 1 cycle after the last `mem_we` when the feature is off.
- **Back-to-back frames:** the next frame is accepted with no gap requirement.

## Configuration
- `UART_LOADER_CSUM_EN` defined: the CSUM byte is expected and checked, and a mismatch goes to ERR.
- Undefined: no CSUM byte and no XOR logic; the frame ends after the last data byte and `error` arises only from framing or length faults.

## Test plan
- **Load two words:** sync, N = 2, bytes 78 56 34 12 EF BE AD DE, CSUM 2A → writes 0x12345678 @0 and 0xDEADBEEF @1, one `core_start`, `error` = 0.
- **Bad checksum:** same frame with CSUM 2B → both words written, `error` = 1, `core_hold` stays 1, no `core_start`.
- **Framing error:** stop bit forced 0 on the third data byte → `error` = 1, no further `mem_we`. A following valid frame then clears `error` and completes.
- **N = 0 and oversize length:** N = 0, CSUM 00 → no `mem_we`, `core_start` pulses. LEN_HI = 0x10 → ERR.
- **Noise and wrap:** a 0.3-bit low glitch is treated as a false start with no byte. With BASE_ADDR = 4095 and N = 2, writes go to 4095 then 0.
- **Reset mid-DATA:** `rst_n` low for 1 cycle → all outputs return to reset values immediately and subsequent bytes are ignored until 0xA5.
